// File: rtl/assignment_4.sv
// 4-bit ripple-carry adder with a registered seven-segment readout.
// Sel picks the sum digit (1) or the carry-out digit (0); the output is active-low {g,f,e,d,c,b,a}.

module assignment_4_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module assignment_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sel,
    output logic [6:0] display
);
    logic [4:0] carry;
    logic [3:0] sum;
    logic [3:0] digit;
    logic [6:0] segments;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_ripple
        assignment_4_fa fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        digit = Sel ? sum : {3'b000, carry[4]};
    end

    always_comb begin
        segments = '1;
        unique case (digit)
            4'h0: segments = 7'h40;
            4'h1: segments = 7'h79;
            4'h2: segments = 7'h24;
            4'h3: segments = 7'h30;
            4'h4: segments = 7'h19;
            4'h5: segments = 7'h12;
            4'h6: segments = 7'h02;
            4'h7: segments = 7'h78;
            4'h8: segments = 7'h00;
            4'h9: segments = 7'h10;
            4'hA: segments = 7'h08;
            4'hB: segments = 7'h03;
            4'hC: segments = 7'h46;
            4'hD: segments = 7'h21;
            4'hE: segments = 7'h06;
            4'hF: segments = 7'h0E;
            default: segments = '1;
        endcase
    end

    // Registering the decoded pattern keeps inputs off any combinational path to display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display <= '1;
        end else begin
            display <= segments;
        end
    end
endmodule

// File: tb/tb_assignment_4.sv
// Scoreboard bench for assignment_4: expected patterns are queued at drive time and
// compared one edge later, after the registered output settles.

module tb_assignment_4;
    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Sel;
    logic [6:0] display;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];
    logic [6:0] seg_tab [16];

    assignment_4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Sel     (Sel),
        .display (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] ref_disp(input logic [3:0] a, input logic [3:0] b,
                                            input logic s, input logic r);
        logic [4:0] total;
        logic [3:0] d;
        total = {1'b0, a} + {1'b0, b};
        d = s ? total[3:0] : {3'b000, total[4]};
        return r ? seg_tab[d] : 7'h7F;
    endfunction

    // Drive one vector after the falling edge, queue its expectation, and stop just past the next rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic r, input logic [6:0] expected);
        @(negedge clk);
        A = a; B = b; Sel = s; rst_n = r;
        exp_q.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        for (int i = 0; i < 2; i++) begin
            apply(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0, 7'h7F);
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, display, e);
            end
        end
        apply(4'h3, 4'h5, 1'b1, 1'b1, 7'h00);
        e = exp_q.pop_front();
        checks++;
        if (display !== e) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", display, e);
        end
    endtask

    task automatic test_zero();
        logic [6:0] e;
        apply(4'h0, 4'h0, 1'b0, 1'b1, 7'h40);
        e = exp_q.pop_front();
        checks++;
        if (display !== e) begin
            errors++;
            $display("FAIL zero_carry: got %h expected %h", display, e);
        end
        apply(4'h0, 4'h0, 1'b1, 1'b1, 7'h40);
        e = exp_q.pop_front();
        checks++;
        if (display !== e) begin
            errors++;
            $display("FAIL zero_sum: got %h expected %h", display, e);
        end
    endtask

    task automatic test_sum_sweep();
        logic [3:0] ta [7] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h4, 4'h3, 4'h8};
        logic [3:0] tb [7] = '{4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h5, 4'h1};
        logic [6:0] te [7] = '{7'h24, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        logic [6:0] e;
        for (int i = 0; i < 7; i++) begin
            apply(ta[i], tb[i], 1'b1, 1'b1, te[i]);
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                $display("FAIL sum_sweep %h+%h: got %h expected %h", ta[i], tb[i], display, e);
            end
        end
    endtask

    task automatic test_carry_wrap();
        logic [3:0] ta [6] = '{4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h9};
        logic [3:0] tb [6] = '{4'h2, 4'h1, 4'h1, 4'hF, 4'hF, 4'h4};
        logic       ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [6:0] te [6] = '{7'h40, 7'h79, 7'h40, 7'h06, 7'h79, 7'h21};
        logic [6:0] e;
        for (int i = 0; i < 6; i++) begin
            apply(ta[i], tb[i], ts[i], 1'b1, te[i]);
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                $display("FAIL carry_wrap %h+%h sel=%0d: got %h expected %h", ta[i], tb[i], ts[i], display, e);
            end
        end
    endtask

    task automatic test_sel_toggle();
        logic [6:0] e;
        for (int i = 0; i < 4; i++) begin
            // 7+9 = 16: sum digit 0, carry digit 1
            apply(4'h7, 4'h9, 1'(i % 2), 1'b1, (i % 2) ? 7'h40 : 7'h79);
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                $display("FAIL sel_toggle[%0d]: got %h expected %h", i, display, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] te [3] = '{7'h46, 7'h7F, 7'h46};
        logic       tr [3] = '{1'b1, 1'b0, 1'b1};
        logic [6:0] e;
        for (int i = 0; i < 3; i++) begin
            apply(4'h6, 4'h6, 1'b1, tr[i], te[i]);
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                $display("FAIL mid_reset[%0d]: got %h expected %h", i, display, e);
            end
        end
    endtask

    task automatic test_no_async_path();
        logic [6:0] e;
        apply(4'h2, 4'h2, 1'b1, 1'b1, 7'h19);
        e = exp_q.pop_front();
        checks++;
        if (display !== e) begin
            errors++;
            $display("FAIL hold_setup: got %h expected %h", display, e);
        end
        @(negedge clk);
        rst_n = 1'b0; A = 4'hF; B = 4'hF; Sel = 1'b0;
        exp_q.push_back(7'h19);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (display !== e) begin
            errors++;
            $display("FAIL no_async_change: got %h expected %h", display, e);
        end
        exp_q.push_back(7'h7F);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (display !== e) begin
            errors++;
            $display("FAIL sync_reset_edge: got %h expected %h", display, e);
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] e;
        int bad = 0;
        for (int v = 0; v < 512; v++) begin
            logic [8:0] vec;
            vec = 9'(v);
            apply(vec[8:5], vec[4:1], vec[0], 1'b1, ref_disp(vec[8:5], vec[4:1], vec[0], 1'b1));
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL exhaustive A=%h B=%h sel=%0d: got %h expected %h",
                             vec[8:5], vec[4:1], vec[0], display, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       s;
            logic       r;
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            s = 1'($urandom_range(1));
            r = ($urandom_range(7) != 0);
            apply(a, b, s, r, ref_disp(a, b, s, r));
            e = exp_q.pop_front();
            checks++;
            if (display !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] A=%h B=%h sel=%0d rst_n=%0d: got %h expected %h",
                         i, a, b, s, r, display, e);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 1'b0; A = '0; B = '0; Sel = 1'b0;
        test_reset();
        test_zero();
        test_sum_sweep();
        test_carry_wrap();
        test_sel_toggle();
        test_mid_reset();
        test_no_async_path();
        test_exhaustive();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/assignment_4.md
ASSIGNMENT_4 -- requirements
Module: assignment_4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 A  input  4  unsigned addend.
REQ-005 B  input  4  unsigned addend.
REQ-006 Sel  input  1  display select: 1 = show sum digit, 0 = show carry-out.
REQ-007 display  output  7  seven-segment pattern, bit order {g,f,e,d,c,b,a}, active-low (0 = segment lit).

Function
REQ-008 The block SHALL compute the 5-bit value A + B with no carry-in, giving sum[3:0] and carry-out cout = bit 4.
REQ-009 The adder SHALL be a 4-bit ripple-carry chain of full adders; the result SHALL equal the arithmetic sum for all 256 input pairs.
REQ-010 When Sel=1, the selected 4-bit value SHALL be sum[3:0], decoded as a hexadecimal digit 0-F.
REQ-011 When Sel=0, the selected 4-bit value SHALL be {3'b000, cout}, showing digit 0 or 1.
REQ-012 The decoder SHALL produce these active-low patterns (hex, gfedcba):
 - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
 - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-013 display SHALL be a register loaded on every rising clk edge with rst_n=1 from the current A, B and Sel.
REQ-014 Latency SHALL be one clock: display reflects inputs sampled at the previous rising edge, with no combinational path from inputs to display.
REQ-015 Wrap-around: sums 16-30 SHALL show sum[3:0] only when Sel=1; overflow SHALL be visible only through Sel=0 (digit 1).
REQ-016 When Sel changes with A and B held, the display SHALL switch between the sum digit and the carry digit on the next edge.
REQ-017 No handshake SHALL exist; inputs are sampled every cycle.

Reset
REQ-018 On a rising edge with rst_n=0, display SHALL load 7'h7F (all segments off), overriding all other inputs.
REQ-019 Reset asserted mid-operation SHALL blank the display on that edge.
REQ-020 On the first edge after rst_n returns to 1, display SHALL show the decoded current inputs.
REQ-021 rst_n SHALL have no asynchronous effect between clock edges.

Verification
REQ-022 rst_n=0 for 2 edges, any A/B/Sel -> display=7F; release -> next edge shows decoded inputs.
REQ-023 A=0, B=0, Sel=0 -> cout=0 -> display=40 after 1 edge; Sel=1 -> sum 0 -> 40.
REQ-024 Sel=1 sweeps: 1+1 -> 24; 1+3 -> 19; 3+2 -> 12; 3+3 -> 02; 4+3 -> 78; 3+5 -> 00; 8+1 -> 10.
REQ-025 A=1, B=2, Sel=0 -> 40; A=F, B=1, Sel=0 -> cout=1 -> 79; same inputs with Sel=1 -> sum 0 -> 40.
REQ-026 A=F, B=F: Sel=1 -> E -> 06; Sel=0 -> 79; A=9, B=4, Sel=1 -> d -> 21.
REQ-027 Exhaustive check: all 512 {A,B,Sel} combinations match the reference sum and decode table one cycle later.
